vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster timing generator, successor to the fixed 640x480 generator. It produces pixel coordinates, a display-enable flag, sync pulses with programmable polarity, and line/frame strobes. All of these outputs are mutually aligned on one register stage. It sits between the pixel clock domain and the pixel/colour pipeline, and is driven by a pixel-rate clock enable so one fast clock can serve several video modes.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)
- COORD_W, 10, coordinate width; H_TOTAL and V_TOTAL must be ≤ 2^COORD_W
- FRAME_W, 16, frame counter width
- VGA_clk  in  1  system/pixel clock, rising-edge
- VGA_rst_n  in  1  reset; synchronous, active-low
- pix_en  in  1  pixel clock enable; counters and outputs advance only when high
- xCount  out  COORD_W  horizontal position, 0..H_TOTAL-1
- yCount  out  COORD_W  vertical position, 0..V_TOTAL-1
- display  out  1  high when xCount < H_ACTIVE and yCount < V_ACTIVE
- VGA_hSync  out  1  horizontal sync, at level H_POL while asserted
- VGA_vSync  out  1  vertical sync, at level V_POL while asserted
- line_start  out  1  one-cycle strobe, xCount == 0
- frame_start  out  1  one-cycle strobe, xCount == 0 and yCount == 0
- vblank_start  out  1  one-cycle strobe, xCount == 0 and yCount == V_ACTIVE
- frame_cnt  out  FRAME_W  completed frames, wraps modulo 2^FRAME_W

## Operation
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
- Internal h_cnt counts 0..H_TOTAL-1 on each pix_en cycle and wraps to 0 after H_TOTAL-1.
- v_cnt increments only on an enabled cycle where h_cnt == H_TOTAL-1. It wraps to 0 after V_TOTAL-1; that same cycle also increments frame_cnt.
- Horizontal sync region: h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- Vertical sync region: v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- All outputs are registered from the current h_cnt/v_cnt on the same enabled edge. xCount/yCount therefore always describe exactly the pixel that display and the sync outputs qualify; there is no one-cycle skew between coordinates and flags.
- When pix_en is low:
  - counters, coordinates, display, syncs and frame_cnt hold;
  - strobes are forced to 0.
- Strobes are high for one VGA_clk cycle only, even if pix_en stays high across multiple cycles.
- Reset (VGA_rst_n low at a clock edge), including mid-frame, sets:
  - h_cnt, v_cnt, xCount, yCount, frame_cnt to 0;
  - display to 0;
  - VGA_hSync to ~H_POL and VGA_vSync to ~V_POL (deasserted);
  - all strobes to 0.
- Reset has priority over pix_en.
- Parameter legality (checked by elaboration assertion): every porch/sync value ≥ 1, H_ACTIVE and V_ACTIVE ≥ 1, totals fit COORD_W.

## Timing
- First enabled edge after reset release registers position (0,0):
  - display=1, line_start=1, frame_start=1;
  - frame_cnt stays 0.
- Latency: one VGA_clk edge from counter state to outputs. Counter state advances on the same edge.
- Line period: H_TOTAL enabled cycles. Frame period: H_TOTAL·V_TOTAL enabled cycles.
- frame_cnt increments on the edge that registers (0,0) for the second and every later frame. It is therefore coincident with frame_start except after reset.
- Simultaneous events:
  - at (0,0), line_start and frame_start are both high;
  - at (0,V_ACTIVE), line_start and vblank_start are both high.
- frame_cnt wraps from 2^FRAME_W-1 to 0 silently.

## Structure
- Package vga_timing_pkg holds:
  - mode constants for 640x480@60 (the defaults above) and 800x600@60 (40/128/88, 1/4/23);
  - a function computing totals.
- Sub-module vga_axis_counter, instantiated twice (horizontal, vertical), provides:
  - parameters ACTIVE, FP, SYNC, BP, POL, W;
  - inputs clk, rst_n, step;
  - outputs count, active, sync, wrap.
- The vertical instance has step = pix_en & horizontal wrap.
- The top level adds the output register stage, strobes and frame_cnt.

## Test plan
- Defaults, pix_en=1 constantly, one full frame:
  - VGA_hSync low exactly for xCount 656..751 (96 cycles per line);
  - VGA_vSync low for yCount 490..491;
  - frame_start period 420000 cycles.
- Defaults, count display-high cycles per frame: 307200. display is never high with xCount ≥ 640 or yCount ≥ 480.
- pix_en toggling 1,0 every cycle:
  - outputs hold on disabled cycles;
  - strobes last one cycle;
  - frame period 840000 VGA_clk cycles.
- Reset asserted at (700, 491), i.e. inside both syncs:
  - next edge gives xCount=yCount=0, syncs deasserted, display=0;
  - after release, first enabled edge gives (0,0) with frame_start=1.
- 800x600 mode with H_POL=V_POL=1:
  - hsync high for 128 cycles starting xCount=840;
  - vblank_start at yCount=600;
  - line period 1056.
- FRAME_W=2, run 5 frames: frame_cnt sequence 0,1,2,3,0,1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Holds the standard video modes and the arithmetic used to size and
// sanity-check an axis (horizontal or vertical) of the raster.
package vga_timing_pkg;

  // One raster axis: visible span followed by front porch, sync, back porch.
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } axis_mode_t;

  // A complete video mode: both axes plus the active level of each sync.
  typedef struct packed {
    axis_mode_t h;
    axis_mode_t v;
    logic       h_pol;
    logic       v_pol;
  } video_mode_t;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs active-low.
  localparam video_mode_t MODE_640X480_60 = '{
    h:     '{active: 640, fp: 16, sync: 96, bp: 48},
    v:     '{active: 480, fp: 10, sync: 2,  bp: 33},
    h_pol: 1'b0,
    v_pol: 1'b0
  };

  // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs active-high.
  localparam video_mode_t MODE_800X600_60 = '{
    h:     '{active: 800, fp: 40, sync: 128, bp: 88},
    v:     '{active: 600, fp: 1,  sync: 4,   bp: 23},
    h_pol: 1'b1,
    v_pol: 1'b1
  };

  // Total positions on one axis, i.e. the counter period.
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // First position inside the sync pulse.
  function automatic int axis_sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  // An axis is usable when every region is non-empty and the whole period
  // can be represented by a counter of width w.
  function automatic bit axis_legal(input int active, input int fp,
                                    input int sync, input int bp,
                                    input int w);
    longint limit;
    limit = longint'(1) << w;
    return (active >= 1) && (fp >= 1) && (sync >= 1) && (bp >= 1) &&
           (w >= 1) && (w <= 30) &&
           (longint'(axis_total(active, fp, sync, bp)) <= limit);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter that advances on step,
// with combinational decode of the visible span, sync pulse and last
// position. The top level registers these decodes alongside the count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0,
  parameter int W      = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         active,
  output logic         sync,
  output logic         wrap
);

  localparam int TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int SYNC_START = axis_sync_start(ACTIVE, FP);
  localparam int SYNC_END   = SYNC_START + SYNC;

  localparam logic [W-1:0] LAST_POS   = W'(TOTAL - 1);
  localparam logic [W-1:0] ACTIVE_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO    = W'(SYNC_START);
  localparam logic [W-1:0] SYNC_HI    = W'(SYNC_END);

  // Refuse to elaborate an axis whose regions are empty or whose period
  // does not fit the counter.
  generate
    if (!axis_legal(ACTIVE, FP, SYNC, BP, W)) begin : g_illegal_axis
      $error("vga_axis_counter: illegal axis parameters");
    end
  endgenerate

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         in_sync;

  // Next position: hold unless stepping, wrap to 0 after the last position.
  always_comb begin
    count_d = count_q;
    if (step) begin
      if (wrap) begin
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Position register; reset wins over step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign wrap    = (count_q == LAST_POS);
  assign active  = (count_q <  ACTIVE_END);
  assign in_sync = (count_q >= SYNC_LO) && (count_q < SYNC_HI);
  assign sync    = in_sync ? POL : ~POL;
  assign count   = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. Two axis counters track the
// raster position; a single output register stage captures coordinates,
// display enable, syncs, strobes and the frame count from the same counter
// state, so every output describes the same pixel.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = MODE_640X480_60.h.active,
  parameter int H_FP     = MODE_640X480_60.h.fp,
  parameter int H_SYNC   = MODE_640X480_60.h.sync,
  parameter int H_BP     = MODE_640X480_60.h.bp,
  parameter int V_ACTIVE = MODE_640X480_60.v.active,
  parameter int V_FP     = MODE_640X480_60.v.fp,
  parameter int V_SYNC   = MODE_640X480_60.v.sync,
  parameter int V_BP     = MODE_640X480_60.v.bp,
  parameter bit H_POL    = MODE_640X480_60.h_pol,
  parameter bit V_POL    = MODE_640X480_60.v_pol,
  parameter int COORD_W  = 10,
  parameter int FRAME_W  = 16
) (
  input  logic               VGA_clk,
  input  logic               VGA_rst_n,
  input  logic               pix_en,
  output logic [COORD_W-1:0] xCount,
  output logic [COORD_W-1:0] yCount,
  output logic               display,
  output logic               VGA_hSync,
  output logic               VGA_vSync,
  output logic               line_start,
  output logic               frame_start,
  output logic               vblank_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam logic [COORD_W-1:0] VBLANK_LINE = COORD_W'(V_ACTIVE);

  // Reject illegal modes at elaboration rather than producing a broken raster.
  generate
    if (!axis_legal(H_ACTIVE, H_FP, H_SYNC, H_BP, COORD_W) ||
        !axis_legal(V_ACTIVE, V_FP, V_SYNC, V_BP, COORD_W) ||
        (FRAME_W < 1)) begin : g_illegal_mode
      $error("vga_timing_gen: illegal timing parameters");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Raster position counters
  // ---------------------------------------------------------------------
  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               h_active;
  logic               v_active;
  logic               h_sync;
  logic               v_sync;
  logic               h_wrap;
  logic               v_wrap;
  logic               v_step;

  // The vertical axis moves one line each time the horizontal axis wraps.
  assign v_step = pix_en & h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_POL),
    .W      (COORD_W)
  ) u_h_axis (
    .clk    (VGA_clk),
    .rst_n  (VGA_rst_n),
    .step   (pix_en),
    .count  (h_cnt),
    .active (h_active),
    .sync   (h_sync),
    .wrap   (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_POL),
    .W      (COORD_W)
  ) u_v_axis (
    .clk    (VGA_clk),
    .rst_n  (VGA_rst_n),
    .step   (v_step),
    .count  (v_cnt),
    .active (v_active),
    .sync   (v_sync),
    .wrap   (v_wrap)
  );

  // ---------------------------------------------------------------------
  // Internal frame counter: bumps on the edge the raster wraps to (0,0).
  // The output copy below picks it up on the following enabled edge, which
  // is the edge that registers (0,0), so frame_cnt moves with frame_start.
  // ---------------------------------------------------------------------
  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] frame_d;

  // Advance the completed-frame count on the last pixel of the frame.
  always_comb begin
    frame_d = frame_q;
    if (v_step && v_wrap) begin
      frame_d = frame_q + 1'b1;
    end
  end

  // Completed-frame register, cleared by reset.
  always_ff @(posedge VGA_clk) begin
    if (!VGA_rst_n) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_d;
    end
  end

  // ---------------------------------------------------------------------
  // Output register stage
  // ---------------------------------------------------------------------
  logic [COORD_W-1:0] x_q,            x_d;
  logic [COORD_W-1:0] y_q,            y_d;
  logic               display_q,      display_d;
  logic               hsync_q,        hsync_d;
  logic               vsync_q,        vsync_d;
  logic               line_start_q,   line_start_d;
  logic               frame_start_q,  frame_start_d;
  logic               vblank_start_q, vblank_start_d;
  logic [FRAME_W-1:0] frame_cnt_q,    frame_cnt_d;

  logic               at_line_start;

  assign at_line_start = (h_cnt == '0);

  // Capture the current position on enabled cycles; otherwise hold levels
  // and drop strobes so each strobe lasts exactly one clock.
  always_comb begin
    x_d            = x_q;
    y_d            = y_q;
    display_d      = display_q;
    hsync_d        = hsync_q;
    vsync_d        = vsync_q;
    frame_cnt_d    = frame_cnt_q;
    line_start_d   = 1'b0;
    frame_start_d  = 1'b0;
    vblank_start_d = 1'b0;
    if (pix_en) begin
      x_d            = h_cnt;
      y_d            = v_cnt;
      display_d      = h_active & v_active;
      hsync_d        = h_sync;
      vsync_d        = v_sync;
      frame_cnt_d    = frame_q;
      line_start_d   = at_line_start;
      frame_start_d  = at_line_start && (v_cnt == '0);
      vblank_start_d = at_line_start && (v_cnt == VBLANK_LINE);
    end
  end

  // Output registers; reset parks syncs at their inactive level.
  always_ff @(posedge VGA_clk) begin
    if (!VGA_rst_n) begin
      x_q            <= '0;
      y_q            <= '0;
      display_q      <= 1'b0;
      hsync_q        <= ~H_POL;
      vsync_q        <= ~V_POL;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      x_q            <= x_d;
      y_q            <= y_d;
      display_q      <= display_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  assign xCount       = x_q;
  assign yCount       = y_q;
  assign display      = display_q;
  assign VGA_hSync    = hsync_q;
  assign VGA_vSync    = vsync_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign vblank_start = vblank_start_q;
  assign frame_cnt    = frame_cnt_q;

endmodule
